assoc_cache_memory: RTL and testbench
=====================================

Name: assoc_cache_memory

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the CPU load/store port and the block-wide data memory; replaces the direct-mapped 8-block cache.
- Generalised address, data and block widths and set count; per-set LRU replacement; zero-wait read hits.

Parameters:
ADDR_W, 8, CPU byte-address width
DATA_W, 8, CPU word width
WORDS, 4, words per block (power of 2, >=2); OFFSET_W = log2(WORDS)
SETS, 4, number of sets (power of 2, >=2); INDEX_W = log2(SETS); TAG_W = ADDR_W-INDEX_W-OFFSET_W

Ports:
clock  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-low reset
read  in  1  CPU read request, held until busywait low
write  in  1  CPU write request, held until busywait low
address  in  ADDR_W  {tag,index,offset}
writedata  in  DATA_W  CPU write data
readdata  out  DATA_W  CPU read data
busywait  out  1  CPU stall
read_mem  out  1  memory block read request
write_mem  out  1  memory block write request
address_mem  out  ADDR_W-OFFSET_W  block address {tag,index}
writedata_mem  out  DATA_W*WORDS  victim block
readdata_mem  in  DATA_W*WORDS  fetched block, word 0 in LSBs
busywait_mem  in  1  memory busy; request complete at a posedge where it is sampled low

Behaviour:
- Reset (reset==0, async): all valid, dirty and LRU bits cleared; state IDLE; busywait, read_mem, write_mem, address_mem, writedata_mem and readdata = 0. Any in-flight memory transaction is abandoned. Data/tag arrays need not be cleared.
- Request = read|write. If both are high, treat as a write.
- Hit: set index valid, tag match in way 0 or way 1, state IDLE.
- busywait = request & ~(IDLE & hit), combinational.
- readdata = selected word of hit way when read & hit & IDLE, else 0.
- Read hit: data available in the same cycle, 0 wait cycles. LRU of the set points to the other way at the posedge.
- Write hit: word written at the posedge, dirty=1, LRU updated; 0 wait cycles.
- Victim selection: an invalid way first (way 0 if both invalid), else the way pointed to by LRU.
- FSM:
  - IDLE: on request & miss -> WRITEBACK if victim valid & dirty, else FETCH.
  - WRITEBACK: write_mem=1, address_mem={victim tag,index}, writedata_mem=victim block. At a posedge with busywait_mem==0 -> FETCH, and victim dirty=0.
  - FETCH: read_mem=1, address_mem={tag_in,index}. At a posedge with busywait_mem==0, install readdata_mem into the victim way (tag=tag_in, valid=1, dirty=0; LRU unchanged) -> IDLE.
- After a fill the held request hits in IDLE; a write then merges the word and sets dirty. Miss latency = memory cycles + 1.
- Memory outputs are held stable while busywait_mem is high. Outside WRITEBACK/FETCH, read_mem, write_mem, address_mem and writedata_mem = 0.
- CPU drops its request mid-miss: the current WRITEBACK/FETCH still completes and the line is installed; no stall afterwards.
- Address changes mid-miss are not supported; the CPU holds address per protocol.
- Index and tag width arithmetic is exact; no wrap other than the natural address field split.

Optional Feature:
CACHE_STATS_EN
- Defined: adds output ports hit_count[15:0] and miss_count[15:0]. Both reset to 0 and saturate at 16'hFFFF.
- hit_count increments once per request completed without entering the miss path.
- miss_count increments once per IDLE->WRITEBACK/FETCH transition. The re-check hit after a fill is not counted as a hit.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan (defaults: TAG_W=4, INDEX_W=2, OFFSET_W=2):
1. Reset, then read 0x00. Required: read_mem=1, address_mem=0x00. Memory returns 0x44332211 -> readdata=0x11 and busywait low. Then read 0x03 -> readdata=0x44 in the same cycle, read_mem stays 0.
2. Write 0x05=0xAB (miss, fetch address_mem=0x01), then read 0x05. Required: 0xAB with no memory traffic and no busywait.
3. Fill 0x00 and 0x10 (same set, both ways), then read 0x00 (hit), then read 0x20. Required: way holding tag 1 evicted. Subsequent read 0x00 hits; read 0x10 misses.
4. Write 0x10=0x5A, fill 0x00, read 0x00, then read 0x20. Required: write_mem=1, address_mem=0x04, writedata_mem[7:0]=0x5A; then read_mem=1, address_mem=0x08.
5. Assert reset low while read_mem=1 with busywait_mem high. Required: read_mem and busywait drop immediately. After release, read 0x00 misses again.
6. CACHE_STATS_EN defined: run scenario 1. Required: miss_count=1, hit_count=1.

Source files
------------

// File: rtl/assoc_cache_memory.sv
// 2-way set-associative write-back, write-allocate data cache with per-set LRU.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module assoc_cache_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  localparam int OFFSET_W = $clog2(WORDS),
  localparam int INDEX_W  = $clog2(SETS),
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int BLK_W    = DATA_W * WORDS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    writedata,
  output logic [DATA_W-1:0]    readdata,
  output logic                 busywait,
  output logic                 read_mem,
  output logic                 write_mem,
  output logic [ADDR_W-OFFSET_W-1:0] address_mem,
  output logic [BLK_W-1:0]     writedata_mem,
  input  logic [BLK_W-1:0]     readdata_mem,
  input  logic                 busywait_mem
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;
  state_t state, state_nxt;

  logic [TAG_W-1:0]    tags   [2][SETS];
  logic [BLK_W-1:0]    blocks [2][SETS];
  logic [1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0]     lru;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag_in;
  assign offset = address[OFFSET_W-1:0];
  assign idx    = address[OFFSET_W +: INDEX_W];
  assign tag_in = address[ADDR_W-1 -: TAG_W];

  logic       request, match, hit, hit_way, victim;
  logic [1:0] way_hit;
  assign request = read | write;

  for (genvar w = 0; w < 2; w++) begin : g_way
    assign way_hit[w] = valid[w][idx] & (tags[w][idx] == tag_in);
  end

  assign match   = |way_hit;
  assign hit     = match & (state == IDLE);
  assign hit_way = way_hit[1];
  assign victim  = !valid[0][idx] ? 1'b0 : (!valid[1][idx] ? 1'b1 : lru[idx]);

  // Miss context is latched so memory traffic stays stable even if the CPU drops its request.
  logic               miss_way;
  logic [INDEX_W-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;

  assign busywait = reset & request & ~hit;
  assign readdata = (reset & read & hit) ? blocks[hit_way][idx][offset*DATA_W +: DATA_W]
                                         : '0;

  always_comb begin
    state_nxt     = state;
    read_mem      = 1'b0;
    write_mem     = 1'b0;
    address_mem   = '0;
    writedata_mem = '0;
    case (state)
      IDLE: if (request & ~match)
        state_nxt = (valid[victim][idx] & dirty[victim][idx]) ? WRITEBACK : FETCH;
      WRITEBACK: begin
        write_mem     = 1'b1;
        address_mem   = {tags[miss_way][miss_idx], miss_idx};
        writedata_mem = blocks[miss_way][miss_idx];
        if (!busywait_mem) state_nxt = FETCH;
      end
      FETCH: begin
        read_mem    = 1'b1;
        address_mem = {miss_tag, miss_idx};
        if (!busywait_mem) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      lru      <= '0;
      miss_way <= 1'b0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (request) begin
          if (match) begin
            lru[idx] <= ~hit_way;
            if (write) dirty[hit_way][idx] <= 1'b1;
          end else begin
            miss_way <= victim;
            miss_idx <= idx;
            miss_tag <= tag_in;
          end
        end
        WRITEBACK: if (!busywait_mem) dirty[miss_way][miss_idx] <= 1'b0;
        FETCH: if (!busywait_mem) begin
          valid[miss_way][miss_idx] <= 1'b1;
          dirty[miss_way][miss_idx] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clock) begin
    if (state == IDLE && request && match && write)
      blocks[hit_way][idx][offset*DATA_W +: DATA_W] <= writedata;
    else if (state == FETCH && !busywait_mem) begin
      blocks[miss_way][miss_idx] <= readdata_mem;
      tags[miss_way][miss_idx]   <= miss_tag;
    end
  end

`ifdef CACHE_STATS_EN
  // The hit that completes a filled request is part of the miss, so it is masked for one cycle.
  logic after_fill;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= (state == FETCH) & ~busywait_mem;
      if (request && hit && !after_fill && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (state == IDLE && request && !match && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_assoc_cache_memory.sv
// Directed bench for assoc_cache_memory: vector table plus reset-during-miss sequence.
module tb_assoc_cache_memory;
  localparam int LAT = 2;

  logic        clock, reset, read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, read_mem, write_mem, busywait_mem;
  logic [5:0]  address_mem;
  logic [31:0] writedata_mem, readdata_mem;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  assoc_cache_memory dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .read_mem(read_mem), .write_mem(write_mem),
    .address_mem(address_mem), .writedata_mem(writedata_mem),
    .readdata_mem(readdata_mem), .busywait_mem(busywait_mem)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: block b word w holds (w+1)*17+b; fixed latency, hold stretches it.
  logic [31:0] mem [64];
  int          cnt;
  logic        hold;
  assign busywait_mem = (read_mem | write_mem) & (hold | (cnt != LAT));
  assign readdata_mem = mem[address_mem];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= 0;
      for (int b = 0; b < 64; b++)
        for (int w = 0; w < 4; w++)
          mem[b][w*8 +: 8] <= 8'((w + 1) * 17 + b);
    end else if ((read_mem | write_mem) && !hold) begin
      if (cnt == LAT) begin
        cnt <= 0;
        if (write_mem) mem[address_mem] <= writedata_mem;
      end else cnt <= cnt + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  logic [7:0] cap_rd, cap_wbw0;
  logic [5:0] cap_faddr, cap_wbaddr;
  bit         cap_f, cap_wb, cap_to;

  task automatic access(input bit w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    read = !w; write = w; address = a; writedata = d;
    cap_f = 0; cap_wb = 0; cap_to = 1; cap_rd = 'x;
    cap_faddr = 'x; cap_wbaddr = 'x; cap_wbw0 = 'x;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (read_mem) begin cap_f = 1; cap_faddr = address_mem; end
      if (write_mem) begin cap_wb = 1; cap_wbaddr = address_mem; cap_wbw0 = writedata_mem[7:0]; end
      if (!busywait) begin cap_rd = readdata; cap_to = 0; break; end
      @(negedge clock);
    end
  endtask

  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    bit         exp_f;
    bit         exp_wb;
    logic [5:0] exp_wbaddr;
    logic [7:0] exp_wbw0;
  } vec_t;

  vec_t v [16];

  initial begin
    v[0]  = '{0, 8'h00, 8'h00, 8'h11, 1, 0, 6'h00, 8'h00};
    v[1]  = '{0, 8'h03, 8'h00, 8'h44, 0, 0, 6'h00, 8'h00};
    v[2]  = '{1, 8'h05, 8'hAB, 8'h00, 1, 0, 6'h00, 8'h00};
    v[3]  = '{0, 8'h05, 8'h00, 8'hAB, 0, 0, 6'h00, 8'h00};
    v[4]  = '{0, 8'h10, 8'h00, 8'h15, 1, 0, 6'h00, 8'h00};
    v[5]  = '{0, 8'h00, 8'h00, 8'h11, 0, 0, 6'h00, 8'h00};
    v[6]  = '{0, 8'h20, 8'h00, 8'h19, 1, 0, 6'h00, 8'h00};
    v[7]  = '{0, 8'h00, 8'h00, 8'h11, 0, 0, 6'h00, 8'h00};
    v[8]  = '{0, 8'h10, 8'h00, 8'h15, 1, 0, 6'h00, 8'h00};
    v[9]  = '{1, 8'h10, 8'h5A, 8'h00, 0, 0, 6'h00, 8'h00};
    v[10] = '{0, 8'h00, 8'h00, 8'h11, 0, 0, 6'h00, 8'h00};
    v[11] = '{0, 8'h20, 8'h00, 8'h19, 1, 1, 6'h04, 8'h5A};
    v[12] = '{0, 8'h10, 8'h00, 8'h5A, 1, 0, 6'h00, 8'h00};
    v[13] = '{0, 8'h06, 8'h00, 8'h34, 0, 0, 6'h00, 8'h00};
    v[14] = '{0, 8'hFF, 8'h00, 8'h83, 1, 0, 6'h00, 8'h00};
    v[15] = '{0, 8'hFC, 8'h00, 8'h50, 0, 0, 6'h00, 8'h00};

    read = 0; write = 0; address = 0; writedata = 0; hold = 0;
    reset = 1;
    #3 reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    #1;
    chk("reset_busywait", busywait, 0);
    chk("reset_read_mem", read_mem, 0);
    chk("reset_write_mem", write_mem, 0);
    chk("reset_address_mem", address_mem, 0);
    chk("reset_readdata", readdata, 0);

    for (int i = 0; i < 16; i++) begin
      access(v[i].w, v[i].a, v[i].d);
      chk($sformatf("v%0d_timeout", i), cap_to, 0);
      chk($sformatf("v%0d_readdata", i), cap_rd, v[i].exp_rd);
      chk($sformatf("v%0d_fetch", i), cap_f, v[i].exp_f);
      if (v[i].exp_f) chk($sformatf("v%0d_fetch_addr", i), cap_faddr, v[i].a[7:2]);
      chk($sformatf("v%0d_writeback", i), cap_wb, v[i].exp_wb);
      if (v[i].exp_wb) begin
        chk($sformatf("v%0d_wb_addr", i), cap_wbaddr, v[i].exp_wbaddr);
        chk($sformatf("v%0d_wb_word0", i), cap_wbw0, v[i].exp_wbw0);
      end
`ifdef CACHE_STATS_EN
      if (i == 1) begin
        chk("stats_miss_count", miss_count, 1);
        @(posedge clock); #1;
        chk("stats_hit_count", hit_count, 1);
      end
`endif
    end

    // Reset asserted while a fetch is stalled by memory.
    @(negedge clock);
    hold = 1; read = 1; write = 0; address = 8'h24;
    repeat (3) @(negedge clock);
    #1;
    chk("stall_read_mem", read_mem, 1);
    chk("stall_busywait", busywait, 1);
    reset = 0;
    #1;
    chk("rst_mid_read_mem", read_mem, 0);
    chk("rst_mid_busywait", busywait, 0);
    chk("rst_mid_address_mem", address_mem, 0);
    @(negedge clock);
    reset = 1; hold = 0; read = 0;

    access(0, 8'h00, 8'h00);
    chk("post_rst_timeout", cap_to, 0);
    chk("post_rst_fetch", cap_f, 1);
    chk("post_rst_fetch_addr", cap_faddr, 6'h00);
    chk("post_rst_readdata", cap_rd, 8'h11);
    access(0, 8'h24, 8'h00);
    chk("post_rst_24_fetch", cap_f, 1);
    chk("post_rst_24_readdata", cap_rd, 8'h1A);

    @(negedge clock);
    read = 0; write = 0;
    #1;
    chk("idle_busywait", busywait, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
